soc_system_key_pio: RTL

SOC_SYSTEM_KEY_PIO -- requirements
Module: soc_system_key_pio

---
 rtl/soc_system_key_pio_pkg.sv | 22 ++
 rtl/soc_system_key_debounce.sv | 72 +++++++
 rtl/soc_system_key_pio.sv | 91 +++++++++
 3 files changed

// File: rtl/soc_system_key_pio_pkg.sv
// Shared address map and edge-select encodings for the key PIO block.
// Debounce is enabled by defining KEY_PIO_DEBOUNCE_EN.
package soc_system_key_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_sel_e;

  function automatic logic edge_hit(input logic [1:0] sel, input logic rise, input logic fall);
    return (rise && (sel == EDGE_RISE || sel == EDGE_BOTH)) ||
           (fall && (sel == EDGE_FALL || sel == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/soc_system_key_debounce.sv
// One key channel: 2-flop synchronizer, stability counter, debounced bit, edge pulses.
// KEY_PIO_DEBOUNCE_EN enables the counter; otherwise s2 feeds the debounced bit directly.
module soc_system_key_debounce
  import soc_system_key_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic INIT            = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic db,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d, s2_q, s2_d, db_q, db_d, upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= INIT;
      s2_q <= INIT;
      db_q <= INIT;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_dc = DEBOUNCE_CYCLES;
`endif

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    db_d = db_q;
    upd  = 1'b0;
`ifdef KEY_PIO_DEBOUNCE_EN
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = '0;
    // Any cycle where s2 agrees with the debounced bit restarts the count.
    if (s2_q != db_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        upd  = 1'b1;
        db_d = s2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
`else
    if (s2_q != db_q) begin
      upd  = 1'b1;
      db_d = s2_q;
    end
`endif
  end

  assign db   = db_q;
  assign rise = upd & s2_q;
  assign fall = upd & ~s2_q;

endmodule

// File: rtl/soc_system_key_pio.sv
// Avalon-MM key PIO: debounced inputs, per-channel edge select, edge capture, masked irq.
// Debounce counters exist only when KEY_PIO_DEBOUNCE_EN is defined.
module soc_system_key_pio
  import soc_system_key_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  logic [WIDTH-1:0]   db, rise, fall, new_edge;
  logic [2*WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0]   irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]   edge_cap_q, edge_cap_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    soc_system_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INIT           (INIT_LEVEL[i])
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .db     (db[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  if (WIDTH < 16) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:2*WIDTH];
  end

  always_comb begin
    wr         = chipselect && !write_n;
    edge_sel_d = edge_sel_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    new_edge   = '0;
    for (int i = 0; i < WIDTH; i++)
      new_edge[i] = edge_hit(edge_sel_q[2*i +: 2], rise[i], fall[i]);
    if (wr) begin
      case (address)
        ADDR_EDGE_SEL: edge_sel_d = writedata[2*WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE_CAP: edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
    // OR-ing new edges after the clear lets a fresh edge beat a same-cycle W1C.
    edge_cap_d = edge_cap_d | new_edge;

    case (address)
      ADDR_DATA:     readdata_d = 32'(db);
      ADDR_EDGE_SEL: readdata_d = 32'(edge_sel_q);
      ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
      default:       readdata_d = 32'(edge_cap_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_sel_q <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      edge_sel_q <= edge_sel_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign irq      = |(edge_cap_q & irq_mask_q);
  assign readdata = readdata_q;

endmodule
